// File: rtl/bcd_sub_seq.sv
// Digit-serial packed-BCD subtractor: diff = x - y - borrow_in.
// Processes one decimal digit per clock, least-significant digit first.
// Handshake: start is accepted whenever busy=0, which includes the done
// cycle. busy is high while digits are being processed. done pulses for
// one cycle when diff/borrow_out/invalid have just been updated.
module bcd_sub_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    input  logic                  borrow_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  borrow_out,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;

    // Operand shift registers: the digit being processed is always in [3:0].
    logic [W-1:0]    x_sh;
    logic [W-1:0]    y_sh;
    // Result shift register: new digits enter at the top and move down,
    // so after DIGITS shifts digit 0 sits in [3:0].
    logic [W-1:0]    acc;
    logic [W-1:0]    acc_next;
    logic            borrow;
    logic            borrow_next;
    logic            inv_acc;
    logic [IW-1:0]   idx;

    logic            accept;
    logic            last;
    logic [3:0]      x_dig;
    logic [3:0]      y_dig;
    logic [4:0]      t;
    logic [3:0]      dig;
    logic            digit_bad;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last       = (idx == IW'(DIGITS - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One-digit subtract with ten's-complement correction on underflow.
    always_comb begin
        x_dig       = x_sh[3:0];
        y_dig       = y_sh[3:0];
        t           = {1'b0, x_dig} - {1'b0, y_dig} - {4'b0000, borrow};
        digit_bad   = (x_dig > 4'd9) || (y_dig > 4'd9);
        dig         = t[3:0];
        borrow_next = 1'b0;
        if (t[4]) begin
            dig         = t[3:0] + 4'd10;
            borrow_next = 1'b1;
        end
        acc_next = (acc >> 4) | (W'(dig) << (W - 4));
    end

    // Operand capture, per-digit accumulation and result publication.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_sh       <= '0;
            y_sh       <= '0;
            acc        <= '0;
            borrow     <= 1'b0;
            inv_acc    <= 1'b0;
            idx        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            invalid    <= 1'b0;
        end else if (accept) begin
            x_sh    <= x;
            y_sh    <= y;
            acc     <= '0;
            borrow  <= borrow_in;
            inv_acc <= 1'b0;
            idx     <= '0;
        end else if (state == CALC) begin
            x_sh    <= x_sh >> 4;
            y_sh    <= y_sh >> 4;
            acc     <= acc_next;
            borrow  <= borrow_next;
            inv_acc <= inv_acc | digit_bad;
            idx     <= idx + IW'(1);
            if (last) begin
                diff       <= acc_next;
                borrow_out <= borrow_next;
                invalid    <= inv_acc | digit_bad;
            end
        end
    end

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Bench for bcd_sub_seq: a 4-digit instance and a 1-digit instance,
// checked against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_bcd_sub_seq;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [15:0]   x;
    logic [15:0]   y;
    logic          borrow_in;
    logic          busy;
    logic          done;
    logic [15:0]   diff;
    logic          borrow_out;
    logic          invalid;

    logic          start1;
    logic [3:0]    x1;
    logic [3:0]    y1;
    logic          borrow_in1;
    logic          busy1;
    logic          done1;
    logic [3:0]    diff1;
    logic          borrow_out1;
    logic          invalid1;

    int checks   = 0;
    int failures = 0;

    // Clock.
    always #5 clk = ~clk;

    bcd_sub_seq #(.DIGITS(D)) dut (
        .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
        .borrow_in(borrow_in), .busy(busy), .done(done), .diff(diff),
        .borrow_out(borrow_out), .invalid(invalid)
    );

    bcd_sub_seq #(.DIGITS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .x(x1), .y(y1),
        .borrow_in(borrow_in1), .busy(busy1), .done(done1), .diff(diff1),
        .borrow_out(borrow_out1), .invalid(invalid1)
    );

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic int bcd2int(input logic [15:0] v, input int nd);
        int r;
        r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'((v >> (4 * i)) & 16'hF);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v, input int nd);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < nd; i++) begin
            r = r | (16'(t % 10) << (4 * i));
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         input int nd, output logic [15:0] e_diff, output logic e_bo,
                         output logic e_inv);
        int r;
        int p;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        e_inv = 1'b0;
        for (int i = 0; i < nd; i++)
            if (((a >> (4 * i)) & 16'hF) > 9 || ((b >> (4 * i)) & 16'hF) > 9) e_inv = 1'b1;
        r = bcd2int(a, nd) - bcd2int(b, nd) - int'(bi);
        e_bo = (r < 0);
        if (r < 0) r = r + p;
        e_diff = int2bcd(r, nd);
    endtask

    function automatic logic [15:0] rand_bcd(input int nd);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) r = r | (16'($urandom_range(0, 9)) << (4 * i));
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation on the 4-digit DUT. lat = number of edges after the
    // start edge until done is seen (-1 on timeout); bcnt = cycles with busy=1.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         output int lat, output int bcnt);
        x = a; y = b; borrow_in = bi; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        bcnt = 0;
        if (busy) bcnt++;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic do_op1(input logic [3:0] a, input logic [3:0] b, input logic bi,
                          output int lat);
        x1 = a; y1 = b; borrow_in1 = bi; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done1) begin
                lat = n;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start1 = 1'b0;
        x = '0; y = '0; borrow_in = 1'b0; x1 = '0; y1 = '0; borrow_in1 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (diff !== 16'h0)      begin failures++; $display("FAIL reset_diff got=%h exp=0000", diff); end
        checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL reset_bo got=%b exp=0", borrow_out); end
        checks++; if (invalid !== 1'b0)    begin failures++; $display("FAIL reset_inv got=%b exp=0", invalid); end
    endtask

    // Done is registered at edge k+D, so it is seen D edges after the start edge
    // and is sampled by the (D+1)th edge.
    task automatic test_basic();
        int lat, bcnt;
        do_op(16'h5000, 16'h1234, 1'b0, lat, bcnt);
        checks++; if (lat !== D)           begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, D); end
        checks++; if (bcnt !== D)          begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bcnt, D); end
        checks++; if (diff !== 16'h3766)   begin failures++; $display("FAIL basic_diff got=%h exp=3766", diff); end
        checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL basic_bo got=%b exp=0", borrow_out); end
        checks++; if (invalid !== 1'b0)    begin failures++; $display("FAIL basic_inv got=%b exp=0", invalid); end
        tick();
        checks++; if (done !== 1'b0)       begin failures++; $display("FAIL basic_done_drop got=%b exp=0", done); end
        checks++; if (diff !== 16'h3766)   begin failures++; $display("FAIL basic_diff_hold got=%h exp=3766", diff); end
    endtask

    task automatic test_wrap();
        int lat, bcnt;
        do_op(16'h0000, 16'h0001, 1'b0, lat, bcnt);
        checks++; if (lat !== D)           begin failures++; $display("FAIL wrap1_latency got=%0d exp=%0d", lat, D); end
        checks++; if (diff !== 16'h9999)   begin failures++; $display("FAIL wrap1_diff got=%h exp=9999", diff); end
        checks++; if (borrow_out !== 1'b1) begin failures++; $display("FAIL wrap1_bo got=%b exp=1", borrow_out); end
        do_op(16'h1000, 16'h0999, 1'b1, lat, bcnt);
        checks++; if (diff !== 16'h0000)   begin failures++; $display("FAIL wrap2_diff got=%h exp=0000", diff); end
        checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL wrap2_bo got=%b exp=0", borrow_out); end
        do_op(16'h0000, 16'h0000, 1'b1, lat, bcnt);
        checks++; if (diff !== 16'h9999)   begin failures++; $display("FAIL wrap3_diff got=%h exp=9999", diff); end
        checks++; if (borrow_out !== 1'b1) begin failures++; $display("FAIL wrap3_bo got=%b exp=1", borrow_out); end
        do_op(16'h4321, 16'h4321, 1'b0, lat, bcnt);
        checks++; if (diff !== 16'h0000 || borrow_out !== 1'b0)
            begin failures++; $display("FAIL equal_ops got=%h/%b exp=0000/0", diff, borrow_out); end
    endtask

    task automatic test_invalid();
        int lat, bcnt;
        do_op(16'h00A0, 16'h0010, 1'b0, lat, bcnt);
        checks++; if (lat !== D)           begin failures++; $display("FAIL inv_latency got=%0d exp=%0d", lat, D); end
        checks++; if (invalid !== 1'b1)    begin failures++; $display("FAIL inv_set got=%b exp=1", invalid); end
        do_op(16'h0042, 16'h0017, 1'b0, lat, bcnt);
        checks++; if (invalid !== 1'b0)    begin failures++; $display("FAIL inv_clear got=%b exp=0", invalid); end
        checks++; if (diff !== 16'h0025)   begin failures++; $display("FAIL inv_next_diff got=%h exp=0025", diff); end
        do_op(16'h0003, 16'hF000, 1'b0, lat, bcnt);
        checks++; if (invalid !== 1'b1)    begin failures++; $display("FAIL inv_top_digit got=%b exp=1", invalid); end
    endtask

    // start held every cycle while busy with changing operands, then a new
    // start in the done cycle.
    task automatic test_back_to_back();
        logic [15:0] e_diff;
        logic        e_bo, e_inv;
        logic [15:0] a2, b2;
        logic        bi2;
        int          lat;
        model(16'h7315, 16'h2468, 1'b1, D, e_diff, e_bo, e_inv);
        x = 16'h7315; y = 16'h2468; borrow_in = 1'b1; start = 1'b1;
        tick();
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            x = rand_bcd(D); y = rand_bcd(D); borrow_in = 1'($urandom_range(0, 1));
            start = 1'b1;
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat !== D)           begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, D); end
        checks++; if (diff !== e_diff || borrow_out !== e_bo)
            begin failures++; $display("FAIL b2b_first_result got=%h/%b exp=%h/%b", diff, borrow_out, e_diff, e_bo); end
        a2 = rand_bcd(D); b2 = rand_bcd(D); bi2 = 1'($urandom_range(0, 1));
        model(a2, b2, bi2, D, e_diff, e_bo, e_inv);
        x = a2; y = b2; borrow_in = bi2; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat !== D)           begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, D); end
        checks++; if (diff !== e_diff || borrow_out !== e_bo)
            begin failures++; $display("FAIL b2b_second_result got=%h/%b exp=%h/%b", diff, borrow_out, e_diff, e_bo); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, seen;
        x = 16'h9876; y = 16'h1234; borrow_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0 || borrow_out !== 1'b0 || invalid !== 1'b0)
            begin failures++; $display("FAIL midreset_outputs got=%b%b_%h_%b%b exp=00_0000_00", busy, done, diff, borrow_out, invalid); end
        seen = 0;
        for (int n = 0; n < D + 4; n++) begin
            tick();
            if (done) seen++;
        end
        checks++; if (seen !== 0)          begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
        do_op(16'h0100, 16'h0001, 1'b0, lat, bcnt);
        checks++; if (lat !== D)           begin failures++; $display("FAIL midreset_latency got=%0d exp=%0d", lat, D); end
        checks++; if (diff !== 16'h0099 || borrow_out !== 1'b0)
            begin failures++; $display("FAIL midreset_result got=%h/%b exp=0099/0", diff, borrow_out); end
    endtask

    task automatic test_random();
        logic [15:0] a, b, e_diff;
        logic        bi, e_bo, e_inv;
        int          lat, bcnt;
        for (int i = 0; i < 40; i++) begin
            a = rand_bcd(D); b = rand_bcd(D); bi = 1'($urandom_range(0, 1));
            model(a, b, bi, D, e_diff, e_bo, e_inv);
            do_op(a, b, bi, lat, bcnt);
            checks++;
            if (lat !== D || diff !== e_diff || borrow_out !== e_bo || invalid !== e_inv) begin
                failures++;
                $display("FAIL random %h-%h-%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=%0d",
                         a, b, bi, diff, borrow_out, invalid, lat, e_diff, e_bo, e_inv, D);
            end
        end
    endtask

    task automatic test_digits1();
        logic [15:0] e_diff;
        logic        e_bo, e_inv, bi;
        logic [3:0]  a, b;
        int          lat;
        do_op1(4'd3, 4'd7, 1'b0, lat);
        checks++; if (lat !== 1)            begin failures++; $display("FAIL d1_latency got=%0d exp=1", lat); end
        checks++; if (diff1 !== 4'd6 || borrow_out1 !== 1'b1)
            begin failures++; $display("FAIL d1_3minus7 got=%h/%b exp=6/1", diff1, borrow_out1); end
        for (int i = 0; i < 12; i++) begin
            a = 4'($urandom_range(0, 9)); b = 4'($urandom_range(0, 9)); bi = 1'($urandom_range(0, 1));
            model({12'h0, a}, {12'h0, b}, bi, 1, e_diff, e_bo, e_inv);
            do_op1(a, b, bi, lat);
            checks++;
            if (lat !== 1 || diff1 !== e_diff[3:0] || borrow_out1 !== e_bo || invalid1 !== e_inv) begin
                failures++;
                $display("FAIL d1_random %h-%h-%b got=%h/%b/%b exp=%h/%b/%b",
                         a, b, bi, diff1, borrow_out1, invalid1, e_diff[3:0], e_bo, e_inv);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_digits1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
